// File: rtl/router_reg_pkt.sv
// Router register block: header/hold/check registers and the byte path to the output FIFO.
// Optional payload length check built only when ROUTER_REG_LEN_CHECK_EN is defined.
module router_reg_pkt #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int PARITY_MODE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     packet_valid,
  input  logic [DATA_W-1:0]        data,
  input  logic                     fifo_full,
  input  logic                     detect_add,
  input  logic                     lfd_state,
  input  logic                     ld_state,
  input  logic                     laf_state,
  input  logic                     lp_state,
  input  logic                     full_state,
  input  logic                     reset_int_reg,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     err,
  output logic                     parity_done,
  output logic                     low_packet_valid,
  output logic                     len_err,
  output logic [DATA_W-ADDR_W-1:0] byte_cnt
);

  localparam int CNT_W = DATA_W - ADDR_W;

  typedef enum logic [2:0] {
    OP_NONE, OP_DETECT, OP_LFD, OP_LD, OP_LAF, OP_LP, OP_RINT
  } op_e;

  op_e               w_op;
  logic [DATA_W-1:0] r_header;
  logic [DATA_W-1:0] r_check;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_vld;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld;
  logic              r_err;
  logic              r_pdone;
  logic              r_lpv;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;

  // full_state is only consumed by an external FSM cross-check.
  logic w_unused_full;
  assign w_unused_full = full_state;

  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] acc,
                                             input logic [DATA_W-1:0] b);
    if (PARITY_MODE == 1) return acc + b;
    else                  return acc ^ b;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_op = OP_NONE;
    if      (detect_add)    w_op = OP_DETECT;
    else if (lfd_state)     w_op = OP_LFD;
    else if (ld_state)      w_op = OP_LD;
    else if (laf_state)     w_op = OP_LAF;
    else if (lp_state)      w_op = OP_LP;
    else if (reset_int_reg) w_op = OP_RINT;
  end

  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  // NOTE: state uses non-blocking assignments; every register, including header/hold, is reset
  // so an aborted packet leaves nothing behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_header   <= '0;
      r_check    <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_err      <= 1'b0;
      r_pdone    <= 1'b0;
      r_lpv      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_dout_vld <= 1'b0;
      unique case (w_op)
        OP_DETECT: begin
          r_header   <= data;
          r_check    <= '0;
          r_cnt      <= '0;
          r_hold_vld <= 1'b0;
        end
        OP_LFD: begin
          r_dout     <= r_header;
          r_dout_vld <= 1'b1;
          r_check    <= r_header;
        end
        OP_LD: begin
          if (!packet_valid) r_lpv <= 1'b1;
          if (fifo_full) begin
            r_hold     <= data;
            r_hold_vld <= 1'b1;
          end else begin
            r_dout     <= data;
            r_dout_vld <= 1'b1;
            r_check    <= fold(r_check, data);
            r_cnt      <= w_cnt_inc;
          end
        end
        OP_LAF: begin
          if (r_hold_vld) begin
            r_dout     <= r_hold;
            r_dout_vld <= 1'b1;
            r_check    <= fold(r_check, r_hold);
            r_cnt      <= w_cnt_inc;
            r_hold_vld <= 1'b0;
          end
        end
        OP_LP: begin
          r_dout     <= data;
          r_dout_vld <= 1'b1;
          r_pdone    <= 1'b1;
          if (data != r_check) r_err <= 1'b1;
        end
        OP_RINT: begin
          r_err   <= 1'b0;
          r_pdone <= 1'b0;
          r_lpv   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic r_len_err;

  always_ff @(posedge clock) begin
    if (reset)
      r_len_err <= 1'b0;
    else if (w_op == OP_LP && r_cnt != r_header[DATA_W-1:ADDR_W])
      r_len_err <= 1'b1;
    else if (w_op == OP_RINT)
      r_len_err <= 1'b0;
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

  assign dout             = r_dout;
  assign dout_valid       = r_dout_vld;
  assign err              = r_err;
  assign parity_done      = r_pdone;
  assign low_packet_valid = r_lpv;
  assign byte_cnt         = r_cnt;

endmodule

// File: tb/tb_router_reg_pkt.sv
// Directed bench for router_reg_pkt: XOR-mode instance plus a sum-mode instance on shared stimulus.
module tb_router_reg_pkt;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_DA   = 7'b1000000;
  localparam logic [6:0] S_LFD  = 7'b0100000;
  localparam logic [6:0] S_LD   = 7'b0010000;
  localparam logic [6:0] S_LAF  = 7'b0001000;
  localparam logic [6:0] S_LP   = 7'b0000100;
  localparam logic [6:0] S_FULL = 7'b0000010;
  localparam logic [6:0] S_RI   = 7'b0000001;

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam logic EXP_LEN_SHORT = 1'b1;
`else
  localparam logic EXP_LEN_SHORT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       packet_valid = 1'b0, fifo_full = 1'b0;
  logic [7:0] data = '0;
  logic       detect_add = 0, lfd_state = 0, ld_state = 0, laf_state = 0;
  logic       lp_state = 0, full_state = 0, reset_int_reg = 0;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1, err0, err1, pd0, pd1, lpv0, lpv1, le0, le1;
  logic [5:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  router_reg_pkt #(.DATA_W(8), .ADDR_W(2), .PARITY_MODE(0)) u_dut0 (
    .clock(clock), .reset(reset), .packet_valid(packet_valid), .data(data),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .lp_state(lp_state),
    .full_state(full_state), .reset_int_reg(reset_int_reg),
    .dout(dout0), .dout_valid(dv0), .err(err0), .parity_done(pd0),
    .low_packet_valid(lpv0), .len_err(le0), .byte_cnt(cnt0));

  router_reg_pkt #(.DATA_W(8), .ADDR_W(2), .PARITY_MODE(1)) u_dut1 (
    .clock(clock), .reset(reset), .packet_valid(packet_valid), .data(data),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .lp_state(lp_state),
    .full_state(full_state), .reset_int_reg(reset_int_reg),
    .dout(dout1), .dout_valid(dv1), .err(err1), .parity_done(pd1),
    .low_packet_valid(lpv1), .len_err(le1), .byte_cnt(cnt1));

  // One clock cycle with the given strobes; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic [6:0] s, input logic [7:0] d,
                     input logic pv = 1'b1, input logic ff = 1'b0);
    {detect_add, lfd_state, ld_state, laf_state, lp_state, full_state, reset_int_reg} = s;
    data = d; packet_valid = pv; fifo_full = ff;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(S_LFD, 8'hFF);
    reset = 1'b0;
    n_checks++; if ({dout0, dv0, err0, pd0, lpv0, le0, cnt0} !== 20'h0) begin
      n_fail++; $display("FAIL reset_dut0 got=%h exp=0", {dout0, dv0, err0, pd0, lpv0, le0, cnt0}); end
    n_checks++; if ({dout1, dv1, err1, pd1, lpv1, le1, cnt1} !== 20'h0) begin
      n_fail++; $display("FAIL reset_dut1 got=%h exp=0", {dout1, dv1, err1, pd1, lpv1, le1, cnt1}); end
  endtask

  task automatic test_good_packet();
    logic [7:0] exp_seq [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    logic [6:0] strb    [5] = '{S_LFD, S_LD, S_LD, S_LD, S_LP};
    cyc(S_DA, 8'h0D);
    n_checks++; if (dv0 !== 1'b0) begin n_fail++; $display("FAIL good_da_valid got=%b exp=0", dv0); end
    for (int i = 0; i < 5; i++) begin
      cyc(strb[i], exp_seq[i]);
      n_checks++; if ({dv0, dout0} !== {1'b1, exp_seq[i]}) begin
        n_fail++; $display("FAIL good_byte%0d got=%b/%h exp=1/%h", i, dv0, dout0, exp_seq[i]); end
    end
    n_checks++; if ({err0, pd0, cnt0, le0} !== {1'b0, 1'b1, 6'd3, 1'b0}) begin
      n_fail++; $display("FAIL good_status err=%b pd=%b cnt=%0d le=%b exp 0/1/3/0", err0, pd0, cnt0, le0); end
    n_checks++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL good_sum_err got=%b exp=1", err1); end
    cyc(S_NONE, 8'h00);
    n_checks++; if (dv0 !== 1'b0) begin n_fail++; $display("FAIL good_pulse got=%b exp=0", dv0); end
  endtask

  task automatic test_bad_parity();
    cyc(S_RI, 8'h00);
    cyc(S_DA, 8'h0D); cyc(S_LFD, 8'h00);
    cyc(S_LD, 8'h11); cyc(S_LD, 8'h22); cyc(S_LD, 8'h33);
    cyc(S_LP, 8'h0C);
    n_checks++; if ({err0, pd0} !== 2'b11) begin n_fail++; $display("FAIL bad_err got=%b%b exp=11", err0, pd0); end
    n_checks++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL bad_sum_err got=%b exp=1", err1); end
    cyc(S_RI, 8'h00);
    n_checks++; if ({err0, pd0, err1, pd1} !== 4'b0000) begin
      n_fail++; $display("FAIL bad_clear got=%b%b%b%b exp=0000", err0, pd0, err1, pd1); end
  endtask

  task automatic test_sum_mode();
    cyc(S_DA, 8'h0D); cyc(S_LFD, 8'h00);
    cyc(S_LD, 8'h11); cyc(S_LD, 8'h22); cyc(S_LD, 8'h33);
    cyc(S_LP, 8'h73);
    n_checks++; if ({err1, err0} !== 2'b01) begin
      n_fail++; $display("FAIL sum_73 got sum=%b xor=%b exp sum=0 xor=1", err1, err0); end
    cyc(S_RI, 8'h00);
  endtask

  task automatic test_fifo_full();
    cyc(S_DA, 8'h0D); cyc(S_LFD, 8'h00);
    cyc(S_LD, 8'h11);
    cyc(S_LD, 8'h22, 1'b1, 1'b1);
    n_checks++; if ({dv0, dout0, cnt0} !== {1'b0, 8'h11, 6'd1}) begin
      n_fail++; $display("FAIL full_hold got=%b/%h/%0d exp=0/11/1", dv0, dout0, cnt0); end
    cyc(S_LAF, 8'h99);
    n_checks++; if ({dv0, dout0, cnt0} !== {1'b1, 8'h22, 6'd2}) begin
      n_fail++; $display("FAIL full_laf got=%b/%h/%0d exp=1/22/2", dv0, dout0, cnt0); end
    cyc(S_LAF, 8'h99);
    n_checks++; if ({dv0, cnt0} !== {1'b0, 6'd2}) begin
      n_fail++; $display("FAIL full_laf_empty got=%b/%0d exp=0/2", dv0, cnt0); end
    cyc(S_LD, 8'h33);
    cyc(S_LP, 8'h0D);
    n_checks++; if ({err0, pd0, cnt0} !== {1'b0, 1'b1, 6'd3}) begin
      n_fail++; $display("FAIL full_final got=%b/%b/%0d exp=0/1/3", err0, pd0, cnt0); end
    cyc(S_RI, 8'h00);
  endtask

  task automatic test_len_check();
    cyc(S_DA, 8'h0D); cyc(S_LFD, 8'h00);
    cyc(S_LD, 8'h11); cyc(S_LD, 8'h22);
    cyc(S_LP, 8'h3E);
    n_checks++; if ({le0, err0, cnt0} !== {EXP_LEN_SHORT, 1'b0, 6'd2}) begin
      n_fail++; $display("FAIL len_short got=%b/%b/%0d exp=%b/0/2", le0, err0, cnt0, EXP_LEN_SHORT); end
    cyc(S_RI, 8'h00);
    n_checks++; if (le0 !== 1'b0) begin n_fail++; $display("FAIL len_clear got=%b exp=0", le0); end
  endtask

  task automatic test_low_pv();
    cyc(S_DA, 8'h0D); cyc(S_LFD, 8'h00);
    cyc(S_LD, 8'h11, 1'b0);
    n_checks++; if ({lpv0, dv0, dout0} !== {1'b1, 1'b1, 8'h11}) begin
      n_fail++; $display("FAIL lpv_set got=%b/%b/%h exp=1/1/11", lpv0, dv0, dout0); end
    cyc(S_NONE, 8'h00);
    n_checks++; if (lpv0 !== 1'b1) begin n_fail++; $display("FAIL lpv_sticky got=%b exp=1", lpv0); end
    cyc(S_RI, 8'h00);
    n_checks++; if (lpv0 !== 1'b0) begin n_fail++; $display("FAIL lpv_clear got=%b exp=0", lpv0); end
  endtask

  task automatic test_priority();
    cyc(S_DA | S_LD, 8'h0D);
    n_checks++; if ({dv0, cnt0} !== {1'b0, 6'd0}) begin
      n_fail++; $display("FAIL prio_da_ld got=%b/%0d exp=0/0", dv0, cnt0); end
    cyc(S_LFD | S_LD, 8'h99);
    n_checks++; if ({dv0, dout0, cnt0} !== {1'b1, 8'h0D, 6'd0}) begin
      n_fail++; $display("FAIL prio_lfd_ld got=%b/%h/%0d exp=1/0d/0", dv0, dout0, cnt0); end
    cyc(S_LP | S_RI, 8'h0D);
    n_checks++; if ({pd0, err0, dout0} !== {1'b1, 1'b0, 8'h0D}) begin
      n_fail++; $display("FAIL prio_lp_ri got=%b/%b/%h exp=1/0/0d", pd0, err0, dout0); end
    cyc(S_FULL, 8'h55);
    n_checks++; if ({dv0, pd0, dout0} !== {1'b0, 1'b1, 8'h0D}) begin
      n_fail++; $display("FAIL full_state_noop got=%b/%b/%h exp=0/1/0d", dv0, pd0, dout0); end
    cyc(S_RI, 8'h00);
  endtask

  task automatic test_saturation();
    cyc(S_DA, 8'h0D);
    for (int i = 0; i < 70; i++) cyc(S_LD, 8'h01);
    n_checks++; if ({cnt0, dout0} !== {6'd63, 8'h01}) begin
      n_fail++; $display("FAIL sat_cnt got=%0d/%h exp=63/01", cnt0, dout0); end
    cyc(S_DA, 8'h0D);
    n_checks++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL sat_clear got=%0d exp=0", cnt0); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp_seq [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    logic [6:0] strb    [5] = '{S_LFD, S_LD, S_LD, S_LD, S_LP};
    cyc(S_DA, 8'h0D); cyc(S_LFD, 8'h00);
    cyc(S_LD, 8'h11, 1'b0);
    cyc(S_LD, 8'h22);
    cyc(S_LD, 8'h33, 1'b1, 1'b1);
    reset = 1'b1;
    cyc(S_LD, 8'h44);
    reset = 1'b0;
    n_checks++; if ({dout0, dv0, err0, pd0, lpv0, le0, cnt0} !== 20'h0) begin
      n_fail++; $display("FAIL midrst_outs got=%h exp=0", {dout0, dv0, err0, pd0, lpv0, le0, cnt0}); end
    cyc(S_LAF, 8'h00);
    n_checks++; if ({dv0, dout0} !== 9'h0) begin
      n_fail++; $display("FAIL midrst_hold got=%b/%h exp=0/00", dv0, dout0); end
    cyc(S_DA, 8'h0D);
    for (int i = 0; i < 5; i++) begin
      cyc(strb[i], exp_seq[i]);
      n_checks++; if ({dv0, dout0} !== {1'b1, exp_seq[i]}) begin
        n_fail++; $display("FAIL midrst_byte%0d got=%b/%h exp=1/%h", i, dv0, dout0, exp_seq[i]); end
    end
    n_checks++; if ({err0, pd0, cnt0, lpv0} !== {1'b0, 1'b1, 6'd3, 1'b0}) begin
      n_fail++; $display("FAIL midrst_final got=%b/%b/%0d/%b exp=0/1/3/0", err0, pd0, cnt0, lpv0); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_sum_mode();
    test_fifo_full();
    test_len_check();
    test_low_pv();
    test_priority();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
